// File: rtl/digit_display_pkg.sv
// Shared constants for the seven-segment digit display: segment bit positions
// and active-high lit patterns for every 4-bit input value.
package digit_display_pkg;

    localparam int unsigned NUM_W = 4;
    localparam int unsigned SEG_W = 8;

    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    // Active-high lit patterns, bit order dp,g,f,e,d,c,b,a
    localparam logic [SEG_W-1:0] PAT_0 = 8'h3F;
    localparam logic [SEG_W-1:0] PAT_1 = 8'h06;
    localparam logic [SEG_W-1:0] PAT_2 = 8'h5B;
    localparam logic [SEG_W-1:0] PAT_3 = 8'h4F;
    localparam logic [SEG_W-1:0] PAT_4 = 8'h66;
    localparam logic [SEG_W-1:0] PAT_5 = 8'h6D;
    localparam logic [SEG_W-1:0] PAT_6 = 8'h7D;
    localparam logic [SEG_W-1:0] PAT_7 = 8'h07;
    localparam logic [SEG_W-1:0] PAT_8 = 8'h7F;
    localparam logic [SEG_W-1:0] PAT_9 = 8'h6F;
    localparam logic [SEG_W-1:0] PAT_A = 8'h77;
    localparam logic [SEG_W-1:0] PAT_B = 8'h7C;
    localparam logic [SEG_W-1:0] PAT_C = 8'h39;
    localparam logic [SEG_W-1:0] PAT_D = 8'h5E;
    localparam logic [SEG_W-1:0] PAT_E = 8'h79;
    localparam logic [SEG_W-1:0] PAT_F = 8'h71;

    localparam logic [SEG_W-1:0] BLANK = 8'h00;

endpackage

// File: rtl/seg_decoder.sv
// Combinational 4-bit value to active-high seven-segment pattern; values 10-15
// show hex letters or blank depending on HEX_MODE.
module seg_decoder
    import digit_display_pkg::*;
#(
    parameter bit HEX_MODE = 1'b0
) (
    input  logic [NUM_W-1:0] number,
    output logic [SEG_W-1:0] pattern_c
);

    always_comb begin
        pattern_c = BLANK;
        case (number)
            4'd0:  pattern_c = PAT_0;
            4'd1:  pattern_c = PAT_1;
            4'd2:  pattern_c = PAT_2;
            4'd3:  pattern_c = PAT_3;
            4'd4:  pattern_c = PAT_4;
            4'd5:  pattern_c = PAT_5;
            4'd6:  pattern_c = PAT_6;
            4'd7:  pattern_c = PAT_7;
            4'd8:  pattern_c = PAT_8;
            4'd9:  pattern_c = PAT_9;
            4'd10: pattern_c = HEX_MODE ? PAT_A : BLANK;
            4'd11: pattern_c = HEX_MODE ? PAT_B : BLANK;
            4'd12: pattern_c = HEX_MODE ? PAT_C : BLANK;
            4'd13: pattern_c = HEX_MODE ? PAT_D : BLANK;
            4'd14: pattern_c = HEX_MODE ? PAT_E : BLANK;
            4'd15: pattern_c = HEX_MODE ? PAT_F : BLANK;
            default: pattern_c = BLANK;
        endcase
        // Decimal point is never used by the countdown digits
        pattern_c[SEG_DP] = 1'b0;
    end

endmodule

// File: rtl/digit_display.sv
// Registered seven-segment driver for one display digit: decode, apply board
// polarity, and hold the result in an asynchronously reset output register.
module digit_display
    import digit_display_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1,
    parameter bit HEX_MODE   = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NUM_W-1:0] number,
    output logic [SEG_W-1:0] seven_segment
);

    localparam logic [SEG_W-1:0] BLANK_DRIVE = ACTIVE_LOW ? ~BLANK : BLANK;

    logic [SEG_W-1:0] lit_c;
    logic [SEG_W-1:0] drive_c;

    seg_decoder #(
        .HEX_MODE (HEX_MODE)
    ) u_seg_decoder (
        .number    (number),
        .pattern_c (lit_c)
    );

    // Whole byte, dp included, is inverted for common-anode boards
    assign drive_c = ACTIVE_LOW ? ~lit_c : lit_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seven_segment <= BLANK_DRIVE;
        end else begin
            seven_segment <= drive_c;
        end
    end

endmodule

// File: tb/tb_digit_display.sv
// Bench for digit_display: four parameter variants share clk/reset/number and
// are checked against a scoreboard of expected segment bytes.
module tb_digit_display;

    typedef struct packed {
        logic [3:0] num;
        logic [7:0] lo_dec;
        logic [7:0] lo_hex;
        logic [7:0] hi_dec;
        logic [7:0] hi_hex;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] number;
    logic [7:0] seg_lo_dec, seg_lo_hex, seg_hi_dec, seg_hi_hex;

    int tests  = 0;
    int failed = 0;
    exp_t exp_q[$];

    // Output bytes for a common-anode board, hex letters enabled
    logic [7:0] al1_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    always #5 clk = ~clk;

    digit_display #(.ACTIVE_LOW(1'b1), .HEX_MODE(1'b0)) u_lo_dec (
        .clk(clk), .reset(reset), .number(number), .seven_segment(seg_lo_dec));
    digit_display #(.ACTIVE_LOW(1'b1), .HEX_MODE(1'b1)) u_lo_hex (
        .clk(clk), .reset(reset), .number(number), .seven_segment(seg_lo_hex));
    digit_display #(.ACTIVE_LOW(1'b0), .HEX_MODE(1'b0)) u_hi_dec (
        .clk(clk), .reset(reset), .number(number), .seven_segment(seg_hi_dec));
    digit_display #(.ACTIVE_LOW(1'b0), .HEX_MODE(1'b1)) u_hi_hex (
        .clk(clk), .reset(reset), .number(number), .seven_segment(seg_hi_hex));

    function automatic logic [7:0] model(input logic [3:0] n, input bit al, input bit hex);
        logic [7:0] b;
        b = al1_tab[n];
        if (!hex && n > 4'd9) b = 8'hFF;
        if (!al) b = ~b;
        return b;
    endfunction

    function automatic exp_t model_all(input logic [3:0] n);
        exp_t e;
        e.num    = n;
        e.lo_dec = model(n, 1'b1, 1'b0);
        e.lo_hex = model(n, 1'b1, 1'b1);
        e.hi_dec = model(n, 1'b0, 1'b0);
        e.hi_hex = model(n, 1'b0, 1'b1);
        return e;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_vs(input string tag, input exp_t e);
        check($sformatf("%s lo_dec n=%0d", tag, e.num), seg_lo_dec, e.lo_dec);
        check($sformatf("%s lo_hex n=%0d", tag, e.num), seg_lo_hex, e.lo_hex);
        check($sformatf("%s hi_dec n=%0d", tag, e.num), seg_hi_dec, e.hi_dec);
        check($sformatf("%s hi_hex n=%0d", tag, e.num), seg_hi_hex, e.hi_hex);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        tests++;
        assert (exp_q.size() != 0) else begin
            failed++;
            $error("FAIL %s scoreboard observed=empty expected=entry", tag);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_vs(tag, e);
        end
    endtask

    task automatic check_blank(input string tag);
        check({tag, " lo_dec"}, seg_lo_dec, 8'hFF);
        check({tag, " lo_hex"}, seg_lo_hex, 8'hFF);
        check({tag, " hi_dec"}, seg_hi_dec, 8'h00);
        check({tag, " hi_hex"}, seg_hi_hex, 8'h00);
    endtask

    task automatic check_dp(input logic [3:0] n);
        check($sformatf("dp lo_dec n=%0d", n), {7'd0, seg_lo_dec[7]}, 8'd1);
        check($sformatf("dp lo_hex n=%0d", n), {7'd0, seg_lo_hex[7]}, 8'd1);
        check($sformatf("dp hi_dec n=%0d", n), {7'd0, seg_hi_dec[7]}, 8'd0);
        check($sformatf("dp hi_hex n=%0d", n), {7'd0, seg_hi_hex[7]}, 8'd0);
    endtask

    // Drive between edges, record expectation, compare just after the edge
    task automatic step(input logic [3:0] n, input string tag);
        @(negedge clk);
        number = n;
        exp_q.push_back(model_all(n));
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    initial begin
        reset  = 1'b1;
        number = 4'd0;
        @(posedge clk);
        #1;
        check_blank("reset_state");
        @(negedge clk);
        reset = 1'b0;

        // Back-to-back sweep of every input in all four variants
        for (int i = 0; i < 16; i++) begin
            step(4'(i), "sweep");
            check_dp(4'(i));
        end

        // Mid-cycle reset while showing 1 (0xF9 on common-anode)
        step(4'd1, "pre_reset");
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_blank("reset_async");
        repeat (2) @(posedge clk);
        #1;
        check_blank("reset_hold");
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();

        step(4'd8, "post_reset");
        step(4'd1, "post_reset");

        // Input change half a cycle before the edge must not show early
        step(4'd3, "latency_a");
        @(negedge clk);
        number = 4'd7;
        #1;
        check_vs("latency_hold", model_all(4'd3));
        exp_q.push_back(model_all(4'd7));
        @(posedge clk);
        #1;
        pop_check("latency_b");

        // Glitches between edges settle back before sampling
        @(negedge clk);
        number = 4'd2;
        #1 number = 4'd9;
        #1 number = 4'd5;
        exp_q.push_back(model_all(4'd5));
        @(posedge clk);
        #1;
        pop_check("glitch");

        step(4'd10, "oor_a");
        step(4'd15, "oor_b");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
